// File: rtl/ex_muldiv_if.sv
// Handshake bundle between the ID/MEM pipeline and the RV32M execute unit.
// master = pipeline side (drives ID operands, FLUSH, MEM_READY); slave = the unit.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic            id_muldiv;
  logic [2:0]      id_func3;
  logic [XLEN-1:0] id_read_data1;
  logic [XLEN-1:0] id_read_data2;
  logic [4:0]      id_rd;
  logic            flush;
  logic            mem_ready;
  logic            busy;
  logic            ex_valid;
  logic [XLEN-1:0] ex_result;
  logic [4:0]      ex_rd;
  logic            ex_write_enable;

  modport master (
    output id_valid, id_muldiv, id_func3, id_read_data1, id_read_data2, id_rd,
    output flush, mem_ready,
    input  busy, ex_valid, ex_result, ex_rd, ex_write_enable
  );

  modport slave (
    input  id_valid, id_muldiv, id_func3, id_read_data1, id_read_data2, id_rd,
    input  flush, mem_ready,
    output busy, ex_valid, ex_result, ex_rd, ex_write_enable
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: latency-counted multiplies, radix-2 restoring divides, held result.
// Define EX_DIV_EARLY_OUT_EN to finish divides with |dividend| < |divisor| one cycle after accept.
module ex_muldiv_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input logic          i_clk,
  input logic          i_rst,
  ex_muldiv_if.slave   bus
);
  localparam int CW       = $clog2(XLEN + MUL_LATENCY) + 1;
  localparam int MUL_LAST = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a, r_b;
  logic [2:0]      r_func3;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_result;
  logic            r_ex_valid;
  logic [XLEN-1:0] r_quo, r_rem, r_dvs;
  logic            r_q_neg, r_r_neg;

  logic              w_accept;
  logic [XLEN-1:0]   w_ma, w_mb;
  logic [2:0]        w_mf;
  logic              w_a_signed, w_b_signed;
  logic [2*XLEN-1:0] w_a_ext, w_b_ext, w_prod;
  logic [XLEN-1:0]   w_mul_res;

  assign w_accept = bus.id_valid & bus.id_muldiv & (r_state == S_IDLE) & ~bus.flush;

  // Operands come straight from ID at accept (single-cycle multiply) and from the latches afterwards.
  assign w_ma       = (r_state == S_IDLE) ? bus.id_read_data1 : r_a;
  assign w_mb       = (r_state == S_IDLE) ? bus.id_read_data2 : r_b;
  assign w_mf       = (r_state == S_IDLE) ? bus.id_func3      : r_func3;
  assign w_a_signed = (w_mf[1:0] == 2'b01) || (w_mf[1:0] == 2'b10);
  assign w_b_signed = (w_mf[1:0] == 2'b01);
  assign w_a_ext    = {{XLEN{w_a_signed & w_ma[XLEN-1]}}, w_ma};
  assign w_b_ext    = {{XLEN{w_b_signed & w_mb[XLEN-1]}}, w_mb};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_mul_res  = (w_mf[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  logic            w_d_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_div_zero, w_ovf, w_early, w_special;
  logic [XLEN-1:0] w_spec_res;

  assign w_d_signed = ~bus.id_func3[0];
  assign w_a_neg    = w_d_signed & bus.id_read_data1[XLEN-1];
  assign w_b_neg    = w_d_signed & bus.id_read_data2[XLEN-1];
  assign w_a_mag    = w_a_neg ? -bus.id_read_data1 : bus.id_read_data1;
  assign w_b_mag    = w_b_neg ? -bus.id_read_data2 : bus.id_read_data2;
  assign w_div_zero = (bus.id_read_data2 == '0);
  assign w_ovf      = w_d_signed && (bus.id_read_data1 == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.id_read_data2 == {XLEN{1'b1}});
`ifdef EX_DIV_EARLY_OUT_EN
  assign w_early    = (w_a_mag < w_b_mag);
`else
  assign w_early    = 1'b0;
`endif
  assign w_special  = w_div_zero | w_ovf | w_early;

  always_comb begin
    w_spec_res = '0;
    if (w_div_zero)
      w_spec_res = bus.id_func3[1] ? bus.id_read_data1 : {XLEN{1'b1}};
    else if (w_ovf)
      w_spec_res = bus.id_func3[1] ? '0 : bus.id_read_data1;
    else
      w_spec_res = bus.id_func3[1] ? bus.id_read_data1 : '0;
  end

  // One restoring step: the partial remainder stays below the divisor, so XLEN bits hold it.
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_qbit;
  logic [XLEN-1:0] w_rem_next, w_quo_next, w_q_fix, w_r_fix, w_div_res;

  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_qbit     = ~w_diff[XLEN];
  assign w_rem_next = w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_next = {r_quo[XLEN-2:0], w_qbit};
  assign w_q_fix    = r_q_neg ? -w_quo_next : w_quo_next;
  assign w_r_fix    = r_r_neg ? -w_rem_next : w_rem_next;
  assign w_div_res  = r_func3[1] ? w_r_fix : w_q_fix;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_func3    <= '0;
      r_rd       <= '0;
      r_result   <= '0;
      r_ex_valid <= 1'b0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
    end else if (bus.flush) begin
      r_state    <= S_IDLE;
      r_ex_valid <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= bus.id_read_data1;
            r_b     <= bus.id_read_data2;
            r_func3 <= bus.id_func3;
            r_rd    <= bus.id_rd;
            r_cnt   <= '0;
            if (!bus.id_func3[2]) begin
              if (MUL_LATENCY == 1) begin
                r_result   <= w_mul_res;
                r_ex_valid <= 1'b1;
                r_state    <= S_DONE;
              end else begin
                r_state <= S_MUL;
              end
            end else if (w_special) begin
              r_result   <= w_spec_res;
              r_ex_valid <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_quo   <= w_a_mag;
              r_dvs   <= w_b_mag;
              r_rem   <= '0;
              r_q_neg <= w_a_neg ^ w_b_neg;
              r_r_neg <= w_a_neg;
              r_state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (r_cnt == CW'(MUL_LAST)) begin
            r_result   <= w_mul_res;
            r_ex_valid <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DIV: begin
          r_quo <= w_quo_next;
          r_rem <= w_rem_next;
          // The final quotient bit and the sign fixup land in the same cycle.
          if (r_cnt == CW'(XLEN - 1)) begin
            r_result   <= w_div_res;
            r_ex_valid <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.mem_ready) begin
            r_ex_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy            = (r_state != S_IDLE);
  assign bus.ex_valid        = r_ex_valid;
  assign bus.ex_write_enable = r_ex_valid;
  assign bus.ex_result       = r_result;
  assign bus.ex_rd           = r_rd;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit (XLEN=32, MUL_LATENCY=2): vector table plus flush/stall/reset sequences.
module tb_ex_muldiv_unit;
  localparam int XLEN = 32;
`ifdef EX_DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(XLEN)) bus ();

  ex_muldiv_unit #(.XLEN(XLEN), .MUL_LATENCY(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", nm, act);
    end
  endtask

  // Scoreboard: every rising EX_VALID must correspond to a queued expectation.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.ex_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got 0x%08h rd %0d, expected no result", bus.ex_result, bus.ex_rd);
        end else begin
          e = sb.pop_front();
          check("sb result", bus.ex_result, e.res);
          check("sb rd", {27'd0, bus.ex_rd}, {27'd0, e.rd});
          check("sb write_enable", {31'd0, bus.ex_write_enable}, 32'd1);
        end
      end
      prev_valid <= bus.ex_valid;
    end
  end

  // Called on a negedge; returns on the negedge where EX_VALID is first seen.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat,
                       input string nm);
    int n;
    bit busy_ok;
    bus.id_valid      = 1'b1;
    bus.id_muldiv     = 1'b1;
    bus.id_func3      = f3;
    bus.id_read_data1 = a;
    bus.id_read_data2 = b;
    bus.id_rd         = rd;
    sb.push_back({exp, rd});
    @(negedge clk);
    bus.id_valid      = 1'b0;
    bus.id_read_data1 = $urandom;
    bus.id_read_data2 = $urandom;
    bus.id_rd         = 5'($urandom);
    n       = 1;
    busy_ok = 1'b1;
    while (!bus.ex_valid && n < 60) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!bus.busy) busy_ok = 1'b0;
    check({nm, " latency"}, 32'(n), 32'(lat));
    check({nm, " busy"}, {31'd0, busy_ok}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] held_res;
    logic [4:0]  held_rd;

    vecs.push_back('{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 2, "MUL 7*-3"});
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, "MULHU ff*ff"});
    vecs.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2, "MULH -1*-1"});
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, "MULHSU -1*ff"});
    vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 2, "MULH min*min"});
    vecs.push_back('{3'b011, 32'h80000000, 32'h00000002, 32'h00000001, 2, "MULHU 2^31*2"});
    vecs.push_back('{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, "DIV -7/2"});
    vecs.push_back('{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, "REM -7/2"});
    vecs.push_back('{3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, "DIV 7/-2"});
    vecs.push_back('{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33, "REM 7/-2"});
    vecs.push_back('{3'b101, 32'd100, 32'd7, 32'd14, 33, "DIVU 100/7"});
    vecs.push_back('{3'b111, 32'd100, 32'd7, 32'd2, 33, "REMU 100/7"});
    vecs.push_back('{3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "DIVU 5/0"});
    vecs.push_back('{3'b111, 32'd5, 32'd0, 32'd5, 1, "REMU 5/0"});
    vecs.push_back('{3'b100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1, "DIV -5/0"});
    vecs.push_back('{3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1, "REM -5/0"});
    vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "DIV min/-1"});
    vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "REM min/-1"});
    vecs.push_back('{3'b101, 32'd3, 32'd10, 32'd0, EO_LAT, "DIVU 3/10"});

    rst               = 1'b1;
    bus.id_valid      = 1'b0;
    bus.id_muldiv     = 1'b0;
    bus.id_func3      = 3'b000;
    bus.id_read_data1 = '0;
    bus.id_read_data2 = '0;
    bus.id_rd         = '0;
    bus.flush         = 1'b0;
    bus.mem_ready     = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("reset ex_result", bus.ex_result, 32'd0);
    check("reset ex_rd", {27'd0, bus.ex_rd}, 32'd0);
    check("reset write_enable", {31'd0, bus.ex_write_enable}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, vecs[i].lat, vecs[i].name);
      @(negedge clk);
      check({vecs[i].name, " valid drops"}, {31'd0, bus.ex_valid}, 32'd0);
    end

    // FLUSH during a divide at T+10; a new op is taken at T+11.
    bus.id_valid      = 1'b1;
    bus.id_muldiv     = 1'b1;
    bus.id_func3      = 3'b101;
    bus.id_read_data1 = 32'd100;
    bus.id_read_data2 = 32'd7;
    bus.id_rd         = 5'd20;
    @(negedge clk);
    bus.id_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy", {31'd0, bus.busy}, 32'd0);
    check("flush ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    do_op(3'b000, 32'd6, 32'd7, 5'd21, 32'd42, 2, "MUL after flush");
    @(negedge clk);

    // FLUSH while the result is held in DONE.
    bus.mem_ready = 1'b0;
    do_op(3'b000, 32'd3, 32'd5, 5'd22, 32'd15, 2, "MUL flushed in DONE");
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b1;
    check("done flush ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("done flush busy", {31'd0, bus.busy}, 32'd0);

    // MEM back-pressure: result and RD stay put while MEM_READY is low.
    bus.mem_ready = 1'b0;
    do_op(3'b000, 32'h1234, 32'h10, 5'd23, 32'h12340, 2, "MUL stalled");
    held_res = 32'h12340;
    held_rd  = 5'd23;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall ex_valid", {31'd0, bus.ex_valid}, 32'd1);
      check("stall ex_result", bus.ex_result, held_res);
      check("stall ex_rd", {27'd0, bus.ex_rd}, {27'd0, held_rd});
      check("stall busy", {31'd0, bus.busy}, 32'd1);
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("release ex_valid", {31'd0, bus.ex_valid}, 32'd0);

    // Asynchronous reset in the middle of a multiply.
    bus.id_valid      = 1'b1;
    bus.id_muldiv     = 1'b1;
    bus.id_func3      = 3'b000;
    bus.id_read_data1 = 32'd9;
    bus.id_read_data2 = 32'd9;
    bus.id_rd         = 5'd24;
    @(negedge clk);
    bus.id_valid = 1'b0;
    check("mid-mul busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst mid-mul busy", {31'd0, bus.busy}, 32'd0);
    check("rst mid-mul ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("rst mid-mul ex_result", bus.ex_result, 32'd0);
    check("rst mid-mul ex_rd", {27'd0, bus.ex_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(3'b000, 32'd2, 32'd3, 5'd25, 32'd6, 2, "MUL after reset");
    @(negedge clk);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
